// File: rtl/boot_loader_pkg.sv
// boot_pkg: shared definitions for the boot loader.
//   SYNC_BYTE_DEF : default frame start marker
//   state_e       : loader FSM state encoding
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte stream from the serial receiver plus the write port
// into the instruction BRAM.
//   rx_data/rx_valid/rx_ready : byte stream, transfer on rx_valid && rx_ready
//   mem_addr/mem_wdata/mem_we : one-cycle word write strobe
// master = loader side, slave = receiver/BRAM side.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 10
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );

endinterface

// File: rtl/boot_loader_byte_pair_assembler.sv
// byte_pair_assembler: joins a high and a low byte into a 16-bit word.
//   clk, rst        : clock, synchronous active-low reset
//   byte_i          : incoming byte
//   hi_load_i       : latch byte_i as the high byte
//   lo_load_i       : combine held high byte with byte_i
//   word_o          : assembled word (valid with word_valid_o)
//   word_valid_o    : one-cycle pulse, the cycle after lo_load_i
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_i,
  input  logic        hi_load_i,
  input  logic        lo_load_i,
  output logic [15:0] word_o,
  output logic        word_valid_o
);

  logic [7:0]  hi_q;
  logic [15:0] word_q;
  logic        valid_q;

  // Reset also drops a pending valid so no partial write escapes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= lo_load_i;
      if (hi_load_i) hi_q <= byte_i;
      if (lo_load_i) word_q <= {hi_q, byte_i};
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a framed image over a byte stream and writes it into
// the instruction BRAM, holding the CPU in reset until the image is loaded.
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, LEN words (high byte first)
//        [, checksum trailer when BOOT_LOADER_CHECKSUM_EN is defined].
//   clk, rst    : clock, synchronous active-low reset
//   bus         : boot_loader_if.master (byte stream in, BRAM write out)
//   restart     : pulse to re-arm from DONE/ERROR
//   cpu_hold    : CPU reset hold, low only in DONE
//   done, error : frame accepted / rejected
//   word_count  : words written in the current frame
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN (8-bit sum check).
//
// state      | meaning
// IDLE       | hunting for SYNC_BYTE, other bytes discarded
// LEN_HI     | waiting for length high byte
// LEN_LO     | waiting for length low byte, range check
// DATA_HI    | waiting for word high byte
// DATA_LO    | waiting for word low byte, word written next cycle
// CHK        | waiting for checksum trailer (checksum builds only)
// DONE       | image loaded, CPU released
// ERROR      | frame rejected
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  boot_loader_if.master   bus,
  input  logic            restart,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] word_count
);

  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_e ST_END = ST_CHK;
`else
  localparam state_e ST_END = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic              accept;
  logic              restart_take;
  logic              hi_load, lo_load;
  logic              word_valid;
  logic [15:0]       word;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_w;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_count_q;
  logic              last_word;

  assign accept       = bus.rx_valid && bus.rx_ready;
  assign restart_take = restart && (state_q == ST_DONE || state_q == ST_ERROR);
  assign len_w        = {len_hi_q, bus.rx_data};
  // word_count already includes every earlier word by the time a low byte lands.
  assign last_word    = (word_count_q + {{ADDR_W{1'b0}}, 1'b1}) == len_q;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (restart_take || state_q == ST_IDLE) begin
      sum_q <= '0;
    end else if (accept && state_q != ST_CHK) begin
      sum_q <= sum_q + bus.rx_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && bus.rx_data == SYNC_BYTE) state_d = ST_LEN_HI;
      ST_LEN_HI:  if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_w == 16'd0)                 state_d = ST_END;
          else if ({1'b0, len_w} > MAX_LEN)   state_d = ST_ERROR;
          else                                state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (accept) state_d = ST_DATA_LO;
      ST_DATA_LO: if (accept) state_d = last_word ? ST_END : ST_DATA_HI;
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) state_d = (bus.rx_data == (~sum_q + 8'd1)) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE:    if (restart) state_d = ST_IDLE;
      ST_ERROR:   if (restart) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rx_ready = (state_q != ST_DONE) && (state_q != ST_ERROR);
    cpu_hold     = (state_q != ST_DONE);
    done         = (state_q == ST_DONE);
    error        = (state_q == ST_ERROR);
    hi_load      = accept && (state_q == ST_DATA_HI);
    lo_load      = accept && (state_q == ST_DATA_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_hi_q     <= '0;
      len_q        <= '0;
      word_count_q <= '0;
    end else begin
      if (accept && state_q == ST_LEN_HI) len_hi_q <= bus.rx_data;
      if (accept && state_q == ST_LEN_LO) len_q    <= len_w[ADDR_W:0];
      if (restart_take)    word_count_q <= '0;
      else if (word_valid) word_count_q <= word_count_q + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  byte_pair_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (bus.rx_data),
    .hi_load_i    (hi_load),
    .lo_load_i    (lo_load),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Address is the pre-increment count during the write cycle.
  assign bus.mem_addr  = word_count_q[ADDR_W-1:0];
  assign bus.mem_wdata = word;
  assign bus.mem_we    = word_valid;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames into boot_loader; expected BRAM writes are
// queued by the stimulus and checked by an independent write monitor.
module tb_boot_loader;

  logic        clk;
  logic        rst;
  logic        restart;
  logic        cpu_hold, done, error;
  logic [10:0] word_count;

  boot_loader_if #(.ADDR_W(10)) bus ();

  boot_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .restart    (restart),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    int          lo_idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fr[$];
  int         acc_cyc[64];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we must match the head of the expectation queue,
  // including landing exactly one cycle after its low byte was accepted.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%0h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data || cyc != acc_cyc[e.lo_idx]) begin
          errors++;
          $display("FAIL write: got %0h@%0h cyc %0d expected %0h@%0h cyc %0d",
                   bus.mem_wdata, bus.mem_addr, cyc, e.data, e.addr, acc_cyc[e.lo_idx]);
        end
      end
    end
  end

  task automatic push_exp(input logic [9:0] a, input logic [15:0] d, input int idx);
    exp_t e;
    e.addr = a; e.data = d; e.lo_idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int idx);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    if (bus.rx_ready !== 1'b1) stalls++;
    @(posedge clk); #1;
    acc_cyc[idx] = cyc;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(fr[i], i);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_all();
    send_range(0, fr.size() - 1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; restart = 1'b0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready",  bus.rx_ready,  1);
    chk("rst_cpu_hold",  cpu_hold,      1);
    chk("rst_mem_we",    bus.mem_we,    0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_done",      done,          0);
    chk("rst_error",     error,         0);
    chk("rst_wcount",    word_count,    0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Two-word frame, with an ignored restart pulse mid-frame.
`ifdef BOOT_LOADER_CHECKSUM_EN
    fr = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
`else
    fr = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`endif
    push_exp(10'd0, 16'h1234, 4);
    push_exp(10'd1, 16'hABCD, 6);
    send_range(0, 3);
    do_restart();
    send_range(4, fr.size() - 1);
    chk("f1_done",     done,         1);
    chk("f1_cpu_hold", cpu_hold,     0);
    chk("f1_error",    error,        0);
    chk("f1_rx_ready", bus.rx_ready, 0);
    @(posedge clk); #1;
    chk("f1_wcount",   word_count,   2);
    bus.rx_data = 8'hA5; bus.rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    chk("f1_done_ignores_rx", done,       1);
    chk("f1_wcount_hold",     word_count, 2);
    do_restart();
    chk("f1_rs_done",     done,         0);
    chk("f1_rs_cpu_hold", cpu_hold,     1);
    chk("f1_rs_rx_ready", bus.rx_ready, 1);
    chk("f1_rs_wcount",   word_count,   0);

    // Leading junk bytes, back-to-back stream.
`ifdef BOOT_LOADER_CHECKSUM_EN
    fr = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h52};
`else
    fr = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
`endif
    stalls = 0;
    push_exp(10'd0, 16'hBEEF, 6);
    send_all();
    chk("f2_stalls", stalls, 0);
    chk("f2_done",   done,   1);
    @(posedge clk); #1;
    chk("f2_wcount", word_count, 1);
    do_restart();

    // Zero-length frame.
`ifdef BOOT_LOADER_CHECKSUM_EN
    fr = {8'hA5, 8'h00, 8'h00, 8'h00};
`else
    fr = {8'hA5, 8'h00, 8'h00};
`endif
    send_all();
    chk("f3_done",     done,     1);
    chk("f3_cpu_hold", cpu_hold, 0);
    @(posedge clk); #1;
    chk("f3_wcount",   word_count, 0);
    do_restart();

    // Length 1025 is out of range.
    fr = {8'hA5, 8'h04, 8'h01};
    send_all();
    chk("f4_error",    error,        1);
    chk("f4_rx_ready", bus.rx_ready, 0);
    chk("f4_cpu_hold", cpu_hold,     1);
    chk("f4_done",     done,         0);
    do_restart();
    chk("f4_rs_error",    error,        0);
    chk("f4_rs_cpu_hold", cpu_hold,     1);
    chk("f4_rs_rx_ready", bus.rx_ready, 1);

    // Length 1024 is the largest legal frame; abandon it with reset.
    fr = {8'hA5, 8'h04, 8'h00};
    send_all();
    chk("f5_len1024_error", error,        0);
    chk("f5_len1024_ready", bus.rx_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset lands on the same edge as a low byte: the write must not happen.
    fr = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    send_range(0, 3);
    bus.rx_data = 8'h22; bus.rx_valid = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    chk("f6_rst_mem_we",   bus.mem_we,   0);
    chk("f6_rst_wcount",   word_count,   0);
    chk("f6_rst_rx_ready", bus.rx_ready, 1);
    chk("f6_rst_cpu_hold", cpu_hold,     1);
    rst = 1'b1;
    @(posedge clk); #1;
`ifdef BOOT_LOADER_CHECKSUM_EN
    fr = {8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'h37};
`else
    fr = {8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE};
`endif
    push_exp(10'd0, 16'hCAFE, 4);
    send_all();
    chk("f6_done", done, 1);
    @(posedge clk); #1;
    chk("f6_wcount", word_count, 1);
    do_restart();

`ifdef BOOT_LOADER_CHECKSUM_EN
    fr = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'hB9};
    push_exp(10'd0, 16'h1234, 4);
    send_all();
    chk("f7_good_done",  done,  1);
    chk("f7_good_error", error, 0);
    do_restart();
    fr = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'hB8};
    push_exp(10'd0, 16'h1234, 4);
    send_all();
    chk("f7_bad_error",    error,    1);
    chk("f7_bad_cpu_hold", cpu_hold, 1);
    chk("f7_bad_done",     done,     0);
    do_restart();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter: ADDR_W, 10, instruction memory address width (1024 words).
REQ-002 Parameter: SYNC_BYTE, 8'hA5, frame start marker.
REQ-003 Port: clk  in  1  system clock; the block is single clock domain.
REQ-004 Port: rst  in  1  reset, synchronous and active-low.
REQ-005 Port: rx_data  in  8  byte from the upstream serial receiver.
REQ-006 Port: rx_valid  in  1  rx_data is valid this cycle.
REQ-007 Port: rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready.
REQ-008 Port: restart  in  1  one-cycle pulse that re-arms the loader from DONE or ERROR.
REQ-009 Port: mem_addr  out  ADDR_W  write address into the instruction BRAM spare port.
REQ-010 Port: mem_wdata  out  16  instruction word to write.
REQ-011 Port: mem_we  out  1  write strobe, one cycle per word.
REQ-012 Port: cpu_hold  out  1  holds the CPU in reset while 1.
REQ-013 Port: done  out  1  image loaded successfully.
REQ-014 Port: error  out  1  frame rejected.
REQ-015 Port: word_count  out  ADDR_W+1  number of words written in the current frame.

Function
REQ-016 Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then LEN words, each sent high byte first; LEN is counted in 16-bit words.
REQ-017 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERROR.
REQ-018 IDLE discards every byte except SYNC_BYTE; SYNC_BYTE moves to LEN_HI.
REQ-019 LEN_LO accept: LEN=0 goes to CHK when checksum is compiled in, else to DONE; LEN > 2^ADDR_W goes to ERROR; otherwise DATA_HI.
REQ-020 DATA_HI latches the high byte and moves to DATA_LO; DATA_LO accept forms the word.
REQ-021 Write latency: mem_we=1 and mem_wdata=word exactly one cycle after the low byte is accepted; mem_addr equals word_count before the increment.
REQ-022 word_count increments in the mem_we cycle.
REQ-023 After the final word, the next state is CHK (macro on) or DONE (macro off); otherwise DATA_HI.
REQ-024 rx_ready=1 in IDLE through CHK, including the mem_we cycle, so back-to-back bytes every cycle lose no data.
REQ-025 rx_ready=0 in DONE and ERROR.
REQ-026 cpu_hold=1 in every state except DONE; it deasserts on the first cycle in DONE.
REQ-027 done=1 only in DONE; error=1 only in ERROR.
REQ-028 restart in DONE or ERROR goes to IDLE, clears word_count, and re-asserts cpu_hold next cycle.
REQ-029 restart is ignored in all other states.
REQ-030 rx_valid is ignored whenever rx_ready=0.

Reset
REQ-031 rst=0 at a clk edge forces IDLE, including mid-frame.
REQ-032 Reset values: rx_ready=1, cpu_hold=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, word_count=0, checksum=0.
REQ-033 Reset never produces a partial write; a pending mem_we is cancelled.

Configuration
REQ-034 Macro BOOT_LOADER_CHECKSUM_EN defined: an 8-bit modular sum of all LEN and data bytes is accumulated, and the CHK state accepts one trailer byte; trailer == two's complement of the sum goes to DONE, otherwise ERROR.
REQ-035 Macro BOOT_LOADER_CHECKSUM_EN undefined: the CHK state and the accumulator are absent, and a frame ends after the last data word.

Structure
REQ-036 Shared package boot_pkg holds the state enum and the default SYNC_BYTE constant.
REQ-037 There is one sub-module, byte_pair_assembler, which joins the HI and LO bytes into a 16-bit word with a valid pulse.
REQ-038 The FSM, counters and checksum reside in boot_loader.

Verification
REQ-039 Send A5 00 02 12 34 AB CD (macro off) -> writes 1234@0 and ABCD@1, each 1 cycle after its LO byte; done=1; cpu_hold falls; word_count=2.
REQ-040 Send bytes 00 FF A5 00 01 BE EF at one per cycle -> the leading 00 FF are dropped; a single write BEEF@0; no ready stalls.
REQ-041 Send A5 04 01 -> error=1, no mem_we, rx_ready=0; a restart pulse then gives IDLE with cpu_hold=1.
REQ-042 Assert rst=0 after A5 00 03 11 22 -> next cycle in IDLE, mem_we=0, word_count=0; a fresh frame loads from address 0.
REQ-043 Macro on: send A5 00 01 12 34 then trailer B9 -> done. Repeating with trailer B8 -> error, cpu_hold stays 1.
REQ-044 Send A5 00 00 -> done immediately (macro off), with no write.
